// File: rtl/fft_lane_rotator.sv
// fft_lane_rotator
//   Cyclic lane rotator for a complex FFT datapath. Each beat carries LANES
//   complex samples; the beat is rotated by a shift amount taken either from
//   iSEL (manual) or from an internal modulo-LANES counter (auto) and is
//   registered once. The output stage is a single ready/valid register with
//   no skid buffer, so oREADY is purely combinational from the output state.
//
// Ports
//   iCLK, iRESET          clock, async active-high reset
//   iX_RE/iX_IM           input lanes, lane k at [k*BIT +: BIT]
//   iVALID/oREADY         input handshake
//   iSEL                  manual shift (iAUTO=0)
//   iAUTO/iSTEP/iSTART    auto mode, counter step per beat, counter clear
//   iDIR                  0: out lane k = in lane k+s, 1: out lane k = in lane k-s
//   oY_RE/oY_IM           rotated lanes, same packing
//   oVALID/iREADY         output handshake
//   oSHIFT                shift applied to the beat on oY_*

// One output lane: picks its source lane modulo LANES. LANES is a power of
// two and SW = log2(LANES), so SW-bit wraparound is the modulo.
module fft_lane_mux #(
  parameter int BIT   = 17,
  parameter int LANES = 4,
  parameter int SW    = 2,
  parameter int K     = 0
) (
  input  logic [LANES-1:0][BIT-1:0] x_re_i,
  input  logic [LANES-1:0][BIT-1:0] x_im_i,
  input  logic [SW-1:0]             s_i,
  input  logic                      dir_i,
  output logic [BIT-1:0]            y_re_o,
  output logic [BIT-1:0]            y_im_o
);
  localparam logic [SW-1:0] KK = SW'(K);

  logic [SW-1:0] idx;

  assign idx    = dir_i ? (KK - s_i) : (KK + s_i);
  assign y_re_o = x_re_i[idx];
  assign y_im_o = x_im_i[idx];
endmodule

module fft_lane_rotator #(
  parameter int BIT   = 17,
  parameter int LANES = 4,
  parameter int SW    = $clog2(LANES)
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [LANES*BIT-1:0] iX_RE,
  input  logic [LANES*BIT-1:0] iX_IM,
  input  logic                 iVALID,
  output logic                 oREADY,
  input  logic [SW-1:0]        iSEL,
  input  logic                 iAUTO,
  input  logic [SW-1:0]        iSTEP,
  input  logic                 iSTART,
  input  logic                 iDIR,
  output logic [LANES*BIT-1:0] oY_RE,
  output logic [LANES*BIT-1:0] oY_IM,
  output logic                 oVALID,
  input  logic                 iREADY,
  output logic [SW-1:0]        oSHIFT
);
  logic [LANES-1:0][BIT-1:0] x_re, x_im, rot_re, rot_im;
  logic [LANES-1:0][BIT-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  logic [SW-1:0]             shift_q, shift_d, cnt_q, cnt_d, s;
  logic                      vld_q, vld_d, acc;

  // Flat ports and packed lane arrays share the same bit layout.
  assign x_re = iX_RE;
  assign x_im = iX_IM;

  assign oREADY = !vld_q || iREADY;
  assign acc    = iVALID && oREADY;

  // iSTART forces s=0 for the beat of the same cycle in auto mode.
  assign s = iAUTO ? (iSTART ? '0 : cnt_q) : iSEL;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fft_lane_mux #(.BIT(BIT), .LANES(LANES), .SW(SW), .K(k)) u_lane (
      .x_re_i (x_re),
      .x_im_i (x_im),
      .s_i    (s),
      .dir_i  (iDIR),
      .y_re_o (rot_re[k]),
      .y_im_o (rot_im[k])
    );
  end

  always_comb begin
    vld_d   = vld_q;
    y_re_d  = y_re_q;
    y_im_d  = y_im_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (acc) begin
      vld_d   = 1'b1;
      y_re_d  = rot_re;
      y_im_d  = rot_im;
      shift_d = s;
    end else if (iREADY) begin
      vld_d   = 1'b0;
    end
    // Counter only moves on accepts (so it freezes under backpressure);
    // iSTART clears it on any other cycle.
    if (acc && iAUTO)  cnt_d = s + iSTEP;
    else if (iSTART)   cnt_d = '0;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_q   <= 1'b0;
      y_re_q  <= '0;
      y_im_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      y_re_q  <= y_re_d;
      y_im_q  <= y_im_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oVALID = vld_q;
  assign oY_RE  = y_re_q;
  assign oY_IM  = y_im_q;
  assign oSHIFT = shift_q;
endmodule

// File: tb/tb_fft_lane_rotator.sv
module tb_fft_lane_rotator;
  localparam int BIT = 17, LANES = 4, SW = 2;

  logic                 clk = 1'b0, rst;
  logic [LANES*BIT-1:0] iX_RE, iX_IM, oY_RE, oY_IM;
  logic                 iVALID, oREADY, iAUTO, iSTART, iDIR, oVALID, iREADY;
  logic [SW-1:0]        iSEL, iSTEP, oSHIFT;

  fft_lane_rotator #(.BIT(BIT), .LANES(LANES)) dut (
    .iCLK(clk), .iRESET(rst), .iX_RE(iX_RE), .iX_IM(iX_IM), .iVALID(iVALID),
    .oREADY(oREADY), .iSEL(iSEL), .iAUTO(iAUTO), .iSTEP(iSTEP), .iSTART(iSTART),
    .iDIR(iDIR), .oY_RE(oY_RE), .oY_IM(oY_IM), .oVALID(oVALID), .iREADY(iREADY),
    .oSHIFT(oSHIFT)
  );

  always #5 clk = ~clk;

  // stimulus lanes
  int xre[LANES], xim[LANES];
  for (genvar k = 0; k < LANES; k++) begin : g_drv
    assign iX_RE[k*BIT +: BIT] = BIT'(xre[k]);
    assign iX_IM[k*BIT +: BIT] = BIT'(xim[k]);
  end

  // reference model: the beat currently expected on the output, plus counter
  int mvld, mshift, mcnt;
  int mre[LANES], mim[LANES];
  int total = 0, bad = 0;
  logic rdy_obs;
  logic rdy_exp;

  function automatic logic [LANES*BIT-1:0] pack(input int a[LANES]);
    logic [LANES*BIT-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*BIT +: BIT] = BIT'(a[k]);
    return r;
  endfunction

  task automatic model_reset();
    mvld = 0; mshift = 0; mcnt = 0;
    for (int k = 0; k < LANES; k++) begin mre[k] = 0; mim[k] = 0; end
  endtask

  task automatic set_pat();
    for (int k = 0; k < LANES; k++) begin xre[k] = k + 1; xim[k] = -(k + 1); end
  endtask

  task automatic set_rand();
    for (int k = 0; k < LANES; k++) begin
      xre[k] = int'($signed(BIT'($urandom)));
      xim[k] = int'($signed(BIT'($urandom)));
    end
  endtask

  // One clock: drive at negedge, sample oREADY, then apply the spec rules to
  // the model at the rising edge. Outputs are compared #1 after the edge.
  task automatic step(input bit v, input int sel, input bit au, input int stp,
                      input bit st, input bit dir, input bit rdy);
    bit acc;
    int s, src;
    @(negedge clk);
    iVALID = v; iSEL = SW'(sel); iAUTO = au; iSTEP = SW'(stp);
    iSTART = st; iDIR = dir; iREADY = rdy;
    #1;
    rdy_obs = oREADY;
    rdy_exp = (mvld == 0) || rdy;
    acc = v && rdy_exp;
    @(posedge clk);
    if (acc) begin
      s = au ? (st ? 0 : mcnt) : sel;
      for (int k = 0; k < LANES; k++) begin
        src = dir ? ((k - s) % LANES + LANES) % LANES : (k + s) % LANES;
        mre[k] = xre[src];
        mim[k] = xim[src];
      end
      mshift = s; mvld = 1;
      if (au)      mcnt = (s + stp) % LANES;
      else if (st) mcnt = 0;
    end else begin
      if (st)  mcnt = 0;
      if (rdy) mvld = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_rand();
    iVALID = 1; iREADY = 0; iAUTO = 1; iSTART = 0; iSEL = 1; iSTEP = 1; iDIR = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", oVALID); end
    total++; if (oY_RE !== '0 || oY_IM !== '0) begin bad++; $display("FAIL reset_data re=%h im=%h want=0", oY_RE, oY_IM); end
    total++; if (oSHIFT !== '0) begin bad++; $display("FAIL reset_shift got=%0d want=0", oSHIFT); end
    total++; if (oREADY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", oREADY); end
    @(negedge clk); rst = 1'b0; iVALID = 0;
  endtask

  task automatic test_manual();
    int w[LANES];
    set_pat();
    step(1, 1, 0, 0, 0, 0, 1);
    w = '{2, 3, 4, 1};
    total++; if (oY_RE !== pack(w)) begin bad++; $display("FAIL man_dn_re got=%h want=%h", oY_RE, pack(w)); end
    w = '{-2, -3, -4, -1};
    total++; if (oY_IM !== pack(w)) begin bad++; $display("FAIL man_dn_im got=%h want=%h", oY_IM, pack(w)); end
    total++; if (oSHIFT !== 2'd1 || oVALID !== 1'b1) begin bad++; $display("FAIL man_dn_ctl shift=%0d vld=%b want 1/1", oSHIFT, oVALID); end
    step(1, 1, 0, 0, 0, 1, 1);
    w = '{4, 1, 2, 3};
    total++; if (oY_RE !== pack(w)) begin bad++; $display("FAIL man_up_re got=%h want=%h", oY_RE, pack(w)); end
    step(1, 0, 0, 0, 0, 1, 1);
    w = '{1, 2, 3, 4};
    total++; if (oY_RE !== pack(w) || oY_IM !== pack(mim)) begin bad++; $display("FAIL man_zero got=%h want=%h", oY_RE, pack(w)); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL man_drain vld=%b want=0", oVALID); end
  endtask

  task automatic test_auto_seq();
    int want[6];
    want = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      set_rand();
      step(1, 3, 1, 1, i == 0, 0, 1);
      total++;
      if (oVALID !== 1'b1 || rdy_obs !== 1'b1 || oSHIFT !== SW'(want[i]) ||
          oY_RE !== pack(mre) || oY_IM !== pack(mim)) begin
        bad++;
        $display("FAIL auto_seq[%0d] vld=%b rdy=%b shift=%0d want_shift=%0d re=%h want=%h",
                 i, oVALID, rdy_obs, oSHIFT, want[i], oY_RE, pack(mre));
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_start_mid();
    int want[5];
    want = '{0, 3, 2, 0, 3};
    for (int i = 0; i < 5; i++) begin
      set_rand();
      step(1, 1, 1, 3, (i == 0) || (i == 3), i[0], 1);
      total++;
      if (oSHIFT !== SW'(want[i]) || oY_RE !== pack(mre) || oY_IM !== pack(mim)) begin
        bad++;
        $display("FAIL start_mid[%0d] shift=%0d want=%0d re=%h want=%h", i, oSHIFT, want[i], oY_RE, pack(mre));
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [LANES*BIT-1:0] hre, him;
    set_rand();
    step(1, 0, 1, 1, 1, 0, 1);   // s=0, counter -> 1
    hre = pack(mre); him = pack(mim);
    for (int i = 0; i < 3; i++) begin
      set_rand();
      step(1, 2, 1, 1, 0, 1, 0);
      total++;
      if (rdy_obs !== 1'b0 || oVALID !== 1'b1 || oY_RE !== hre || oY_IM !== him || oSHIFT !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold[%0d] rdy=%b vld=%b shift=%0d re=%h want=%h", i, rdy_obs, oVALID, oSHIFT, oY_RE, hre);
      end
    end
    set_rand();
    step(1, 0, 1, 1, 0, 0, 1);   // drain + accept, counter was frozen at 1
    total++;
    if (rdy_obs !== 1'b1 || oVALID !== 1'b1 || oSHIFT !== 2'd1 || oY_RE !== pack(mre)) begin
      bad++; $display("FAIL bp_release rdy=%b vld=%b shift=%0d want=1", rdy_obs, oVALID, oSHIFT);
    end
    set_rand();
    step(1, 0, 1, 1, 0, 0, 1);
    total++;
    if (oVALID !== 1'b1 || oSHIFT !== 2'd2 || oY_IM !== pack(mim)) begin
      bad++; $display("FAIL bp_next vld=%b shift=%0d want=2", oVALID, oSHIFT);
    end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_rand();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 1),
           $urandom_range(0, 3) != 0);
      total++;
      if (rdy_obs !== rdy_exp || oVALID !== (mvld != 0) ||
          (mvld != 0 && (oSHIFT !== SW'(mshift) || oY_RE !== pack(mre) || oY_IM !== pack(mim)))) begin
        bad++;
        $display("FAIL rand[%0d] rdy=%b/%b vld=%b/%0d shift=%0d/%0d re=%h/%h",
                 i, rdy_obs, rdy_exp, oVALID, mvld, oSHIFT, mshift, oY_RE, pack(mre));
      end
    end
  endtask

  task automatic test_reset_mid();
    set_rand();
    step(1, 0, 1, 1, 1, 0, 1);
    step(1, 0, 1, 1, 0, 0, 1);   // counter now 2
    step(0, 0, 1, 1, 0, 0, 0);   // held beat
    @(negedge clk); rst = 1'b1; #1;
    model_reset();
    total++;
    if (oVALID !== 1'b0 || oY_RE !== '0 || oY_IM !== '0 || oSHIFT !== '0 || oREADY !== 1'b1) begin
      bad++; $display("FAIL reset_mid vld=%b shift=%0d rdy=%b re=%h want 0/0/1/0", oVALID, oSHIFT, oREADY, oY_RE);
    end
    @(negedge clk); rst = 1'b0;
    set_rand();
    step(1, 3, 1, 1, 0, 0, 1);
    total++;
    if (oVALID !== 1'b1 || oSHIFT !== 2'd0 || oY_RE !== pack(mre)) begin
      bad++; $display("FAIL post_reset vld=%b shift=%0d want 1/0", oVALID, oSHIFT);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_seq();
    test_start_mid();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_lane_rotator.md
FFT_LANE_ROTATOR -- requirements
Module: fft_lane_rotator

Interface
REQ-001 SHALL have parameter BIT, default 17: width of each signed real/imag sample.
REQ-002 SHALL have parameter LANES, default 4: number of complex lanes; power of two, 2..16.
REQ-003 SHALL have parameter SW, default $clog2(LANES): width of the shift amount.
REQ-004 iCLK  input  1  single clock; all state changes on rising edge.
REQ-005 iRESET  input  1  asynchronous, active-high reset.
REQ-006 iX_RE  input  LANES*BIT  lane k real part at bits [k*BIT +: BIT].
REQ-007 iX_IM  input  LANES*BIT  lane k imag part, same packing.
REQ-008 iVALID  input  1  input beat valid.
REQ-009 oREADY  output  1  block can accept an input beat.
REQ-010 iSEL  input  SW  manual shift amount, used when iAUTO=0.
REQ-011 iAUTO  input  1  1 = shift from internal counter; 0 = shift from iSEL.
REQ-012 iSTEP  input  SW  counter increment per accepted beat in auto mode.
REQ-013 iSTART  input  1  one-cycle pulse; clears the rotation counter.
REQ-014 iDIR  input  1  0 = rotate down, 1 = rotate up.
REQ-015 oY_RE  output  LANES*BIT  rotated real parts, same packing as iX_RE.
REQ-016 oY_IM  output  LANES*BIT  rotated imag parts.
REQ-017 oVALID  output  1  output beat valid.
REQ-018 iREADY  input  1  downstream accepts the output beat.
REQ-019 oSHIFT  output  SW  shift amount applied to the beat now on oY_*.

Function
REQ-020 Accept: input beat accepted on a rising edge where iVALID=1 and oREADY=1.
REQ-021 oREADY SHALL equal (!oVALID || iREADY), combinationally; no skid buffer.
REQ-022 Latency: an accepted beat SHALL appear on oY_*, with oVALID=1, exactly one cycle after acceptance.
REQ-023 Effective shift s: iSEL when iAUTO=0; when iAUTO=1, 0 if iSTART=1 that cycle, else the counter value.
REQ-024 iDIR=0: oY lane k SHALL equal input lane (k+s) mod LANES, matching the existing 4-lane mixer order.
REQ-025 iDIR=1: oY lane k SHALL equal input lane (k-s) mod LANES.
REQ-026 RE and IM SHALL use the same mapping; samples are moved bit-exact, with no arithmetic or sign change.
REQ-027 Counter (SW bits): on an accept with iAUTO=1, counter <= (s + iSTEP) mod LANES; wraparound is natural modulo 2^SW.
REQ-028 iSTART=1 without an accept: counter <= 0.
REQ-029 iSTART=1 with an accept in auto mode: the beat uses s=0 and counter <= iSTEP.
REQ-030 Accept with iAUTO=0: counter unchanged, unless iSTART=1, in which case counter <= 0.
REQ-031 Hold: while oVALID=1 and iREADY=0, oY_*, oSHIFT and oVALID SHALL stay stable, and the counter SHALL not advance.
REQ-032 oVALID clears on a cycle where iREADY=1 and no new beat is accepted.
REQ-033 Same-cycle drain and accept SHALL replace the output beat with no bubble, sustaining one beat per cycle.
REQ-034 oSHIFT SHALL register s together with the data of the same beat.
REQ-035 iSEL, iAUTO, iSTEP and iDIR SHALL be sampled only on accept cycles.

Reset
REQ-036 While iRESET=1, oVALID, oY_RE, oY_IM, oSHIFT and the counter SHALL be 0, asynchronously.
REQ-037 oREADY SHALL be 1 while in reset; beats are not accepted until iRESET deasserts.
REQ-038 Reset mid-stream SHALL drop any held beat; the first post-reset auto beat uses s=0.

Verification (LANES=4, BIT=17; lane values RE=k+1, IM=-(k+1))
REQ-039 Manual, iDIR=0, iSEL=1, one beat -> next cycle oY_RE lanes = {2,3,4,1}, oY_IM = {-2,-3,-4,-1}, oSHIFT=1, oVALID=1.
REQ-040 Manual, iDIR=1, iSEL=1 -> oY_RE = {4,1,2,3}; iSEL=0 -> output equals input.
REQ-041 Auto, iSTEP=1, iSTART on the first of 6 back-to-back beats, iREADY=1 -> oSHIFT sequence 0,1,2,3,0,1, one output beat per cycle.
REQ-042 Auto, iSTEP=3, 3 beats then iSTART on the 4th -> oSHIFT 0,3,2,0; counter = 3 afterwards.
REQ-043 Backpressure: iREADY=0 for 3 cycles with oVALID=1 -> oREADY=0, output and counter frozen; iREADY=1 releases the held beat, then the next beat follows with no bubble.
REQ-044 Assert iRESET mid-stream with oVALID=1 -> oVALID=0, outputs 0, oREADY=1; the next auto beat gives oSHIFT=0.
